unified_mem_arbiter: RTL and testbench

- Shares one single-port memory bus between the IF-stage instruction fetch port and the MEM-stage data port of the 5-stage MIPS pipeline.
- Sequences each access as a request/acknowledge transaction with variable bus latency.
- Gives data accesses priority over fetches, with a starvation guard so fetches still make progress.
- Reports per-port stall to the pipeline controller and flags bus timeouts.

---
 rtl/unified_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch port and the data port.
// Data has priority. A starvation guard forces a fetch grant, and a bus timeout aborts the transaction.
module unified_mem_arbiter #(
   parameter int STARVE_LIMIT = 3,
   parameter int TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_stall,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_ack,
   output logic        mem_stall,
   output logic        bus_cs,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_dout,
   input  logic [31:0] bus_din,
   input  logic        bus_ack,
   output logic        bus_err,
   output logic [1:0]  dbg_state
);

   // Handshake: a requester holds its request until its one-cycle ack. It updates the request
   // on the edge that ends the ack cycle, so the arbiter never sees a served request twice.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      INST = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [7:0] L_WAIT_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0] L_STARVE_MAX = 8'(STARVE_LIMIT);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_wait_cnt;
   logic [7:0] r_starve_cnt;
   logic       w_data_req;
   logic       w_if_forced;
   logic       w_grant_data;
   logic       w_grant_inst;
   logic       w_timeout;
   logic       w_end;

   assign w_data_req  = mem_ren | mem_wen;
   assign w_if_forced = if_req & (r_starve_cnt == L_STARVE_MAX);
   assign if_stall    = if_req & ~if_ack;
   assign mem_stall   = w_data_req & ~mem_ack;
   assign dbg_state   = r_state;

   always_comb begin
      w_next       = r_state;
      w_grant_data = 1'b0;
      w_grant_inst = 1'b0;
      w_timeout    = 1'b0;
      w_end        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_data_req && !w_if_forced) begin
               w_grant_data = 1'b1;
               w_next       = DATA;
            end else if (if_req) begin
               w_grant_inst = 1'b1;
               w_next       = INST;
            end
         end
         DATA, INST: begin
            w_timeout = !bus_ack && (r_wait_cnt == L_WAIT_LAST);
            w_end     = bus_ack | w_timeout;
            if (w_end) w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_wait_cnt   <= '0;
         r_starve_cnt <= '0;
         bus_cs       <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_dout     <= '0;
         bus_err      <= 1'b0;
         if_ack       <= 1'b0;
         mem_ack      <= 1'b0;
         if_rdata     <= '0;
         mem_rdata    <= '0;
      end else begin
         r_state <= w_next;
         if_ack  <= w_end && (r_state == INST);
         mem_ack <= w_end && (r_state == DATA);

         if (w_grant_data || w_grant_inst) begin
            bus_cs     <= 1'b1;
            bus_we     <= w_grant_data & mem_wen;
            bus_addr   <= w_grant_data ? mem_addr : if_addr;
            bus_dout   <= w_grant_data ? mem_wdata : 32'd0;
            r_wait_cnt <= '0;
         end else if (w_end) begin
            bus_cs <= 1'b0;
            // A timed-out transaction returns zero rather than whatever sits on bus_din.
            if (r_state == DATA) mem_rdata <= bus_ack ? bus_din : 32'd0;
            else                 if_rdata  <= bus_ack ? bus_din : 32'd0;
            if (w_timeout) bus_err <= 1'b1;
         end else if (bus_cs) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end

         if (w_grant_inst) begin
            r_starve_cnt <= '0;
         end else if (w_grant_data) begin
            if (!if_req)                           r_starve_cnt <= '0;
            else if (r_starve_cnt != L_STARVE_MAX) r_starve_cnt <= r_starve_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a transaction-level reference model is compared on every cycle,
// and hand-computed literals pin the key results.
module tb_unified_mem_arbiter;
   localparam int STARVE_LIMIT = 3;
   localparam int TIMEOUT      = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_ack, if_stall;
   logic        mem_ren = 1'b0, mem_wen = 1'b0;
   logic [31:0] mem_addr = '0, mem_wdata = '0;
   logic [31:0] mem_rdata;
   logic        mem_ack, mem_stall;
   logic        bus_cs, bus_we, bus_err;
   logic [31:0] bus_addr, bus_dout;
   logic [31:0] bus_din = '0;
   logic        bus_ack = 1'b0;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_stall(mem_stall),
      .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
      .bus_din(bus_din), .bus_ack(bus_ack), .bus_err(bus_err), .dbg_state(dbg_state)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: actual=\"%s\" required=\"%s\"", name, act, exp);
      end
   endtask

   // Bus memory contents seen by the responder.
   function automatic logic [31:0] bus_word(input logic [31:0] a);
      if (a == 32'h100) return 32'h2008000A;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Bus responder: 0 = ack after ack_delay cycles of bus_cs, 1 = ack always high, 2 = never ack.
   int bus_mode = 0;
   int ack_delay = 1;
   int cs_cycles = 0;
   always @(posedge clk) begin
      #1;
      case (bus_mode)
         1: bus_ack = 1'b1;
         2: bus_ack = 1'b0;
         default: begin
            if (bus_cs) begin
               cs_cycles++;
               bus_ack = (cs_cycles == ack_delay);
            end else begin
               cs_cycles = 0;
               bus_ack   = 1'b0;
            end
         end
      endcase
      bus_din = bus_ack ? bus_word(bus_addr) : (32'hBADBAD00 + 32'(cyc));
   end

   // Reference model: tracks the transaction in flight (port, cycles on the bus, response pending)
   // and the fetch-waiting streak of data grants.
   int          m_port = 0;      // 0 none, 1 data, 2 fetch
   bit          m_resp = 1'b0;
   int          m_elapsed = 0;
   int          m_streak = 0;
   int          m_grants[$];
   logic        e_cs = 0, e_we = 0, e_err = 0, e_if_ack = 0, e_mem_ack = 0;
   logic [31:0] e_addr = '0, e_dout = '0, e_if_rdata = '0, e_mem_rdata = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_port = 0; m_resp = 1'b0; m_elapsed = 0; m_streak = 0;
         e_cs = 0; e_we = 0; e_err = 0; e_if_ack = 0; e_mem_ack = 0;
         e_addr = '0; e_dout = '0; e_if_rdata = '0; e_mem_rdata = '0;
      end else begin
         e_if_ack  = 1'b0;
         e_mem_ack = 1'b0;
         if (m_resp) begin
            m_resp = 1'b0;
         end else if (m_port != 0) begin
            m_elapsed++;
            if (bus_ack || m_elapsed == TIMEOUT) begin
               if (m_port == 1) begin
                  e_mem_rdata = bus_ack ? bus_din : 32'd0;
                  e_mem_ack   = 1'b1;
               end else begin
                  e_if_rdata = bus_ack ? bus_din : 32'd0;
                  e_if_ack   = 1'b1;
               end
               if (!bus_ack) e_err = 1'b1;
               e_cs   = 1'b0;
               m_port = 0;
               m_resp = 1'b1;
            end
         end else if ((mem_ren || mem_wen) && !(if_req && m_streak >= STARVE_LIMIT)) begin
            m_port = 1; m_elapsed = 0; e_cs = 1'b1;
            e_addr = mem_addr; e_we = mem_wen; e_dout = mem_wdata;
            m_streak = if_req ? ((m_streak < STARVE_LIMIT) ? m_streak + 1 : STARVE_LIMIT) : 0;
            m_grants.push_back(1);
         end else if (if_req) begin
            m_port = 2; m_elapsed = 0; e_cs = 1'b1;
            e_addr = if_addr; e_we = 1'b0; e_dout = 32'd0;
            m_streak = 0;
            m_grants.push_back(2);
         end
      end
   end

   // Per-cycle compare plus a record of DUT grants and acks.
   bit   chk_on = 1'b0;
   logic prev_cs = 1'b0;
   int   d_grants[$];
   int   d_grant_cyc[$];
   int   n_if_ack = 0, n_mem_ack = 0;
   int   if_ack_cyc = 0, mem_ack_cyc = 0;

   always @(negedge clk) begin
      if (chk_on) begin
         chk("bus_cs", 32'(bus_cs), 32'(e_cs));
         chk("bus_we", 32'(bus_we), 32'(e_we));
         chk("bus_addr", bus_addr, e_addr);
         chk("bus_dout", bus_dout, e_dout);
         chk("bus_err", 32'(bus_err), 32'(e_err));
         chk("if_ack", 32'(if_ack), 32'(e_if_ack));
         chk("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
         chk("if_rdata", if_rdata, e_if_rdata);
         chk("mem_rdata", mem_rdata, e_mem_rdata);
         chk("if_stall", 32'(if_stall), 32'(if_req & ~e_if_ack));
         chk("mem_stall", 32'(mem_stall), 32'((mem_ren | mem_wen) & ~e_mem_ack));
      end
      if (bus_cs && !prev_cs) begin
         d_grants.push_back(int'(dbg_state));
         d_grant_cyc.push_back(cyc);
      end
      prev_cs = bus_cs;
      if (if_ack)  begin n_if_ack++;  if_ack_cyc  = cyc; end
      if (mem_ack) begin n_mem_ack++; mem_ack_cyc = cyc; end
   end

   function automatic string log_str(input int q[$]);
      string s = "";
      foreach (q[i]) s = {s, (q[i] == 1) ? "D" : "I"};
      return s;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic at_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      d_grants.delete();
      d_grant_cyc.delete();
      m_grants.delete();
      n_if_ack  = 0;
      n_mem_ack = 0;
   endtask

   task automatic wait_ack(input bit want_mem, input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (want_mem ? mem_ack : if_ack) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_cs(input int max, output bit found);
      found = 1'b0;
      for (int i = 0; i < max; i++) begin
         tick();
         if (bus_cs) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      bit got_mem;
      int cs_cnt;
      int acks_before;

      // Reset
      at_edge();
      chk_on = 1'b1;
      repeat (2) at_edge();
      tick();
      chk("rst_bus_cs", 32'(bus_cs), 32'd0);
      chk("rst_bus_err", 32'(bus_err), 32'd0);
      chk("rst_acks", 32'({if_ack, mem_ack}), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      at_edge();
      rst = 1'b0;

      // Isolated fetch
      clear_logs();
      bus_mode = 0; ack_delay = 1;
      if_req = 1'b1; if_addr = 32'h100;
      wait_ack(1'b0, 20, found);
      chk("t1_found", 32'(found), 32'd1);
      chk("t1_if_rdata", if_rdata, 32'h2008000A);
      chk("t1_if_stall_in_ack", 32'(if_stall), 32'd0);
      chk("t1_bus_we", 32'(bus_we), 32'd0);
      at_edge();
      if_req = 1'b0;
      repeat (3) tick();
      chk("t1_if_ack_count", 32'(n_if_ack), 32'd1);
      chk_str("t1_dut_grants", log_str(d_grants), "I");

      // Simultaneous fetch and store: data first
      clear_logs();
      if_req = 1'b1; if_addr = 32'h104;
      mem_wen = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
      wait_cs(10, found);
      chk("t2_cs_found", 32'(found), 32'd1);
      chk("t2_bus_we", 32'(bus_we), 32'd1);
      chk("t2_bus_dout", bus_dout, 32'hDEADBEEF);
      chk("t2_bus_addr", bus_addr, 32'h40);
      wait_ack(1'b1, 20, found);
      chk("t2_mem_found", 32'(found), 32'd1);
      at_edge();
      mem_wen = 1'b0;
      wait_ack(1'b0, 20, found);
      chk("t2_if_found", 32'(found), 32'd1);
      at_edge();
      if_req = 1'b0;
      repeat (3) tick();
      chk("t2_order", 32'(mem_ack_cyc < if_ack_cyc), 32'd1);
      chk_str("t2_dut_grants", log_str(d_grants), "DI");
      chk_str("t2_model_grants", log_str(m_grants), "DI");

      // Starvation guard
      clear_logs();
      if_req = 1'b1; if_addr = 32'h200;
      mem_ren = 1'b1; mem_addr = 32'h1000;
      for (int k = 0; k < 5; k++) begin
         found = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_ack || if_ack) begin found = 1'b1; break; end
         end
         chk("t3_found", 32'(found), 32'd1);
         got_mem = mem_ack;
         at_edge();
         if (k == 4) begin
            if_req = 1'b0; mem_ren = 1'b0;
         end else if (got_mem) begin
            mem_addr = mem_addr + 32'd4;
         end else begin
            if_addr = if_addr + 32'd4;
         end
      end
      repeat (3) tick();
      chk_str("t3_dut_grants", log_str(d_grants), "DDDID");
      chk_str("t3_model_grants", log_str(m_grants), "DDDID");
      chk("t3_mem_acks", 32'(n_mem_ack), 32'd4);
      chk("t3_if_acks", 32'(n_if_ack), 32'd1);

      // Timeout
      clear_logs();
      bus_mode = 2;
      mem_ren = 1'b1; mem_addr = 32'h300;
      cs_cnt = 0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus_cs) cs_cnt++;
         if (mem_ack) begin found = 1'b1; break; end
      end
      chk("t4_found", 32'(found), 32'd1);
      chk("t4_cs_cycles", 32'(cs_cnt), 32'd64);
      chk("t4_mem_rdata", mem_rdata, 32'd0);
      chk("t4_bus_err", 32'(bus_err), 32'd1);
      at_edge();
      mem_ren = 1'b0;
      bus_mode = 0; ack_delay = 2;
      at_edge();
      mem_ren = 1'b1; mem_addr = 32'h304;
      wait_ack(1'b1, 20, found);
      chk("t4_good_found", 32'(found), 32'd1);
      chk("t4_good_rdata", mem_rdata, 32'h0304FCFB);
      chk("t4_err_sticky", 32'(bus_err), 32'd1);
      at_edge();
      mem_ren = 1'b0;
      repeat (2) tick();

      // Reset in the middle of a fetch
      clear_logs();
      ack_delay = 6;
      if_req = 1'b1; if_addr = 32'h400;
      wait_cs(10, found);
      chk("t5_cs_found", 32'(found), 32'd1);
      at_edge();
      rst = 1'b1;
      at_edge();
      rst = 1'b0; if_req = 1'b0;
      tick();
      chk("t5_bus_cs", 32'(bus_cs), 32'd0);
      chk("t5_bus_err", 32'(bus_err), 32'd0);
      acks_before = n_if_ack + n_mem_ack;
      at_edge();
      bus_mode = 1;
      repeat (3) at_edge();
      bus_mode = 0; ack_delay = 1;
      repeat (2) tick();
      chk("t5_no_ack", 32'(n_if_ack + n_mem_ack), 32'(acks_before));
      chk("t5_idle_cs", 32'(bus_cs), 32'd0);
      at_edge();
      if_req = 1'b1; if_addr = 32'h100;
      wait_ack(1'b0, 20, found);
      chk("t5_refetch_found", 32'(found), 32'd1);
      chk("t5_if_rdata", if_rdata, 32'h2008000A);
      at_edge();
      if_req = 1'b0;
      repeat (3) tick();

      // Back-to-back with bus_ack held high
      clear_logs();
      bus_mode = 1;
      at_edge();
      mem_ren = 1'b1; mem_addr = 32'h600;
      for (int i = 0; i < 4; i++) begin
         wait_ack((i % 2) == 0, 20, found);
         chk("t6_found", 32'(found), 32'd1);
         at_edge();
         if (i == 3) begin
            if_req = 1'b0; mem_ren = 1'b0;
         end else if ((i % 2) == 0) begin
            mem_ren = 1'b0; if_req = 1'b1; if_addr = 32'h700 + 32'(4 * i);
         end else begin
            if_req = 1'b0; mem_ren = 1'b1; mem_addr = 32'h600 + 32'(4 * i);
         end
      end
      repeat (4) tick();
      chk_str("t6_dut_grants", log_str(d_grants), "DIDI");
      chk_str("t6_model_grants", log_str(m_grants), "DIDI");
      chk("t6_grant_count", 32'(d_grant_cyc.size()), 32'd4);
      for (int j = 1; j < 4; j++)
         chk("t6_spacing", 32'(d_grant_cyc[j] - d_grant_cyc[j-1]), 32'd3);
      chk("t6_mem_acks", 32'(n_mem_ack), 32'd2);
      chk("t6_if_acks", 32'(n_if_ack), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
